// File: rtl/tx_defs.sv
// Shared definitions for the serial transmitter: FSM state encoding and
// the counter-width helper.
package tx_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width is max(1, clog2(width)) so a 1- or 2-bit word still gets a real counter bit.
  function automatic int CNT_W(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Mod-MOD up-counter with synchronous clear and terminal-count output;
// frames each word inside the serial transmitter.
module bit_counter #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word input, one bit per
// clock on q with bit-valid and last-bit qualifiers, gapless back-to-back.
module piso_tx
  import tx_defs::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_last
);

  localparam int CW = CNT_W(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic             accept;

  bit_counter #(
    .MOD (WIDTH),
    .W   (CW)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  assign q_valid = (state_q == ST_SHIFT);
  assign q_last  = q_valid && cnt_tc;
  assign q       = q_valid && ((MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0]);
  // Held low during reset so a producer never sees a handshake the block cannot honour.
  assign din_ready = rst_n && (!q_valid || q_last);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (accept) begin
      state_d = ST_SHIFT;
      sr_d    = din;
      cnt_clr = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      sr_d   = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
      cnt_en = 1'b1;
      if (cnt_tc) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Randomised and directed bench for piso_tx in three configurations,
// checked against a per-word bit-position reference model.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din0 = '0;
  logic [3:0] din1 = '0;
  logic [0:0] din2 = '0;
  logic [2:0] dv = '0;
  logic [2:0] q_o, qv_o, ql_o, rdy_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: word in flight, next bit position, bits still to be sent.
  logic [3:0] word [3];
  int         pos  [3];
  int         rem  [3];
  int         wid  [3] = '{4, 4, 1};
  bit         msb  [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(dv[0]), .din_ready(rdy_o[0]),
    .q(q_o[0]), .q_valid(qv_o[0]), .q_last(ql_o[0])
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(dv[1]), .din_ready(rdy_o[1]),
    .q(q_o[1]), .q_valid(qv_o[1]), .q_last(ql_o[1])
  );

  piso_tx #(.WIDTH(1), .MSB_FIRST(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .din(din2), .din_valid(dv[2]), .din_ready(rdy_o[2]),
    .q(q_o[2]), .q_valid(qv_o[2]), .q_last(ql_o[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input int i);
    int k;
    k = msb[i] ? (wid[i] - 1 - pos[i]) : pos[i];
    return word[i][k];
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("q[%0d]", i),       {31'd0, q_o[i]},   {31'd0, (rem[i] > 0) ? exp_bit(i) : 1'b0});
      check_eq($sformatf("q_valid[%0d]", i), {31'd0, qv_o[i]},  (rem[i] > 0)  ? 32'd1 : 32'd0);
      check_eq($sformatf("q_last[%0d]", i),  {31'd0, ql_o[i]},  (rem[i] == 1) ? 32'd1 : 32'd0);
      check_eq($sformatf("din_ready[%0d]", i), {31'd0, rdy_o[i]}, (rem[i] <= 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_in_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_q[%0d]", tag, i),       {31'd0, q_o[i]},   32'd0);
      check_eq($sformatf("%s_q_valid[%0d]", tag, i), {31'd0, qv_o[i]},  32'd0);
      check_eq($sformatf("%s_q_last[%0d]", tag, i),  {31'd0, ql_o[i]},  32'd0);
      check_eq($sformatf("%s_ready[%0d]", tag, i),   {31'd0, rdy_o[i]}, 32'd0);
    end
  endtask

  // One clock: check this cycle's outputs, then drive inputs for the coming edge.
  task automatic step(input logic [2:0] v, input logic [11:0] d);
    logic [3:0] di;
    @(negedge clk);
    check_outputs();
    dv   = v;
    din0 = d[3:0];
    din1 = d[7:4];
    din2 = d[8];
    for (int i = 0; i < 3; i++) begin
      di = d[4*i +: 4];
      if (v[i] && rem[i] <= 1) begin
        word[i] = di;
        pos[i]  = 0;
        rem[i]  = wid[i];
      end else if (rem[i] > 0) begin
        pos[i]++;
        rem[i]--;
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) begin
      step(3'b000, 12'($urandom));
    end
  endtask

  // Asserts reset away from any edge; outputs must drop without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    dv    = '0;
    #1;
    check_in_reset("rst_async");
    @(negedge clk);
    check_in_reset("rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0;
      pos[i] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      word[i] = '0;
      pos[i]  = 0;
      rem[i]  = 0;
    end
    #12;
    check_in_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single word on both 4-bit instances, with a mid-word valid pulse and din churn.
    step(3'b011, {4'h1, 4'b1000, 4'b1011});
    idle_steps(1);
    step(3'b011, {4'h0, 4'h7, 4'h4});
    idle_steps(4);

    // Back-to-back: A held, then 5 presented in the last-bit cycle.
    step(3'b001, 12'h00A);
    step(3'b001, 12'h00A);
    step(3'b001, 12'h00A);
    step(3'b001, 12'h00A);
    step(3'b001, 12'h005);
    idle_steps(5);

    // WIDTH=1 continuous valid, alternating data.
    step(3'b100, 12'h100);
    step(3'b100, 12'h000);
    step(3'b100, 12'h100);
    idle_steps(2);

    // Abort a word mid-flight, then send all-ones cleanly.
    step(3'b011, {4'h0, 4'h6, 4'h9});
    idle_steps(1);
    do_reset();
    step(3'b111, 12'hFFF);
    idle_steps(5);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] v;
      for (int i = 0; i < 3; i++) begin
        v[i] = ($urandom_range(3) != 0);
      end
      step(v, 12'($urandom));
      if ($urandom_range(149) == 0) begin
        do_reset();
      end
    end
    idle_steps(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
